// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester ALU arbiter: ALU control codes, FSM state, owner tag and operand bundle.
package alu_arb_pkg;

  localparam int ALU_WORD_W = 32;
  localparam int ALU_CTRL_W = 4;

  // ALU control codes; these values are forwarded to the ALU unmodified.
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    COLLECT = 2'd2,
    RESP    = 2'd3
  } alu_arb_state_e;

  typedef logic owner_t;

  typedef struct packed {
    logic [ALU_CTRL_W-1:0] ctrl;
    logic [ALU_WORD_W-1:0] a;
    logic [ALU_WORD_W-1:0] b;
  } alu_op_t;

endpackage

// File: rtl/alu_rr_arbiter2.sv
// Two-way grant logic. Round-robin by default; ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins).
module alu_rr_arbiter2
  import alu_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o,
  output owner_t     grant_idx_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_fixed;
  assign unused_fixed = ^{clk, reset, accept_i};

  always_comb begin
    grant_idx_o = valid_i[0] ? 1'b0 : 1'b1;
  end
`else
  // Holds the index granted on the most recent accept; reset to 1 so requester 0 wins the first tie.
  owner_t last_q;

  always_comb begin
    if (valid_i == 2'b11) grant_idx_o = ~last_q;
    else                  grant_idx_o = valid_i[0] ? 1'b0 : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)         last_q <= 1'b1;
    else if (accept_i) last_q <= grant_idx_o;
  end
`endif

  always_comb begin
    grant_o = 2'b00;
    if (valid_i != 2'b00) grant_o[grant_idx_o] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between the execute path (req 0) and the address generator (req 1).
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
// Handshake: a transfer happens on any cycle where valid and ready are both high; valid never waits on ready.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WORD_SIZE = ALU_WORD_W,
  parameter int CTRL_W    = ALU_CTRL_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [CTRL_W-1:0]    req0_ctrl,
  input  logic [WORD_SIZE-1:0] req0_a,
  input  logic [WORD_SIZE-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [CTRL_W-1:0]    req1_ctrl,
  input  logic [WORD_SIZE-1:0] req1_a,
  input  logic [WORD_SIZE-1:0] req1_b,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic [CTRL_W-1:0]    alu_control,
  output logic [WORD_SIZE-1:0] alu_in_1,
  output logic [WORD_SIZE-1:0] alu_in_2,
  input  logic [WORD_SIZE-1:0] alu_out,
  output logic                 busy,
  output alu_arb_state_e       state_o
);

  alu_arb_state_e state_q, state_d;
  alu_op_t        op_q;
  owner_t         owner_q;
  logic [WORD_SIZE-1:0] rsp_data_q;

  logic [1:0] grant;
  owner_t     grant_idx;
  logic       accept;
  logic       owner_rsp_ready;

  assign accept          = (state_q == IDLE) && ((grant & {req1_valid, req0_valid}) != 2'b00);
  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  alu_rr_arbiter2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .valid_i     ({req1_valid, req0_valid}),
    .accept_i    (accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = COLLECT;
      COLLECT: state_d = RESP;
      RESP:    if (owner_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
      end
      RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
      end
      default: ;
    endcase
  end

  // Operand registers drive the ALU directly and hold in IDLE so the ALU inputs stay quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '{ctrl: ALU_ADD, a: '0, b: '0};
      owner_q    <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        owner_q <= grant_idx;
        op_q    <= grant_idx ? '{ctrl: req1_ctrl, a: req1_a, b: req1_b}
                             : '{ctrl: req0_ctrl, a: req0_a, b: req0_b};
      end
      if (state_q == COLLECT) rsp_data_q <= alu_out;
    end
  end

  assign alu_control = op_q.ctrl;
  assign alu_in_1    = op_q.a;
  assign alu_in_2    = op_q.b;
  assign rsp_data    = rsp_data_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a registered ALU model; expectations are hand-computed constants.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_ctrl = ALU_ADD, req1_ctrl = ALU_ADD;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [3:0]  alu_control;
  logic [31:0] alu_in_1, alu_in_2;
  logic [31:0] alu_out = '0;
  logic        busy;
  alu_arb_state_e state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .alu_control(alu_control),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_out(alu_out),
    .busy(busy), .state_o(state_dbg)
  );

  always #5 clk = ~clk;

  // Registered ALU model: result appears the cycle after the inputs are presented.
  always @(posedge clk) begin
    case (alu_control)
      ALU_ADD: alu_out <= alu_in_1 + alu_in_2;
      ALU_SUB: alu_out <= alu_in_1 - alu_in_2;
      ALU_AND: alu_out <= alu_in_1 & alu_in_2;
      ALU_OR:  alu_out <= alu_in_1 | alu_in_2;
      ALU_XOR: alu_out <= alu_in_1 ^ alu_in_2;
      ALU_SLL: alu_out <= alu_in_1 << alu_in_2[4:0];
      ALU_SRL: alu_out <= alu_in_1 >> alu_in_2[4:0];
      ALU_SRA: alu_out <= $signed(alu_in_1) >>> alu_in_2[4:0];
      default: alu_out <= '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_rdy0", 32'(req0_ready), 0);
    check("rst_rdy1", 32'(req1_ready), 0);
    check("rst_rspv", 32'({rsp1_valid, rsp0_valid}), 0);
    check("rst_data", rsp_data, 0);
    check("rst_in1", alu_in_1, 0);
    check("rst_in2", alu_in_2, 0);
    check("rst_ctrl", 32'(alu_control), 32'(ALU_ADD));
    check("rst_busy", 32'(busy), 0);

    // Single op: ADD 5 + 7 on requester 0
    req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_a = 32'd5; req0_b = 32'd7;
    #1;
    check("s_rdy0", 32'(req0_ready), 1);
    check("s_rdy1", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0;
    #1;
    check("s_c1_state", 32'(state_dbg), 32'(EXEC));
    check("s_c1_busy", 32'(busy), 1);
    check("s_c1_in1", alu_in_1, 32'd5);
    check("s_c1_in2", alu_in_2, 32'd7);
    tick();
    check("s_c2_state", 32'(state_dbg), 32'(COLLECT));
    check("s_c2_busy", 32'(busy), 1);
    check("s_c2_rspv", 32'(rsp0_valid), 0);
    tick();
    check("s_c3_rspv0", 32'(rsp0_valid), 1);
    check("s_c3_rspv1", 32'(rsp1_valid), 0);
    check("s_c3_data", rsp_data, 32'd12);
    check("s_c3_busy", 32'(busy), 1);
    tick();
    check("s_c4_state", 32'(state_dbg), 32'(IDLE));
    check("s_c4_busy", 32'(busy), 0);

    // Simultaneous requests from a fresh pointer
    reset = 1'b1; tick(); reset = 1'b0;
    req0_valid = 1'b1; req0_ctrl = ALU_SUB; req0_a = 32'd10;     req0_b = 32'd3;
    req1_valid = 1'b1; req1_ctrl = ALU_ADD; req1_a = 32'h1000;   req1_b = 32'h20;
    for (int k = 0; k < 4; k++) begin
      logic exp_own;
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_own = 1'b0;
`else
      exp_own = k[0];
`endif
      #1;
      check($sformatf("sim%0d_rdy0", k), 32'(req0_ready), 32'(!exp_own));
      check($sformatf("sim%0d_rdy1", k), 32'(req1_ready), 32'(exp_own));
      tick(); tick(); tick();
      check($sformatf("sim%0d_rspv0", k), 32'(rsp0_valid), 32'(!exp_own));
      check($sformatf("sim%0d_rspv1", k), 32'(rsp1_valid), 32'(exp_own));
      check($sformatf("sim%0d_data", k), rsp_data, exp_own ? 32'h1020 : 32'd7);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure on requester 1: XOR 0xFF00 ^ 0x0FF0
    req1_valid = 1'b1; req1_ctrl = ALU_XOR; req1_a = 32'hFF00; req1_b = 32'h0FF0;
    rsp1_ready = 1'b0;
    #1;
    check("bp_rdy1", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_a = 32'd1; req0_b = 32'd2;
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_rspv1", k), 32'(rsp1_valid), 1);
      check($sformatf("bp%0d_data", k), rsp_data, 32'h0000F0F0);
      check($sformatf("bp%0d_rdy0", k), 32'(req0_ready), 0);
      tick();
    end
    rsp1_ready = 1'b1;
    tick();
    check("bp_idle", 32'(state_dbg), 32'(IDLE));
    check("bp_rdy0_after", 32'(req0_ready), 1);
    req0_valid = 1'b0;

    // Arithmetic shift right passes the control code through
    req0_valid = 1'b1; req0_ctrl = ALU_SRA; req0_a = 32'h80000000; req0_b = 32'd4;
    tick();
    req0_valid = 1'b0;
    check("sra_exec_ctrl", 32'(alu_control), 32'(ALU_SRA));
    tick();
    check("sra_coll_ctrl", 32'(alu_control), 32'(ALU_SRA));
    tick();
    check("sra_data", rsp_data, 32'hF8000000);
    tick();

    // Reset asserted during COLLECT
    req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_a = 32'd3; req0_b = 32'd4;
    tick();
    req0_valid = 1'b0;
    tick();
    check("rm_collect", 32'(state_dbg), 32'(COLLECT));
    reset = 1'b1;
    tick();
    check("rm_state", 32'(state_dbg), 32'(IDLE));
    check("rm_rspv", 32'({rsp1_valid, rsp0_valid}), 0);
    check("rm_data", rsp_data, 0);
    check("rm_in1", alu_in_1, 0);
    check("rm_ctrl", 32'(alu_control), 32'(ALU_ADD));
    reset = 1'b0;
    req1_valid = 1'b1; req1_ctrl = ALU_ADD; req1_a = 32'd1; req1_b = 32'd1;
    #1;
    check("rm_rdy1", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    tick(); tick();
    check("rm_rspv1", 32'(rsp1_valid), 1);
    check("rm_data2", rsp_data, 32'd2);
    tick();

    // Non-owner ready is ignored: AND 0xF0F0 & 0xFF00
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_ctrl = ALU_AND; req0_a = 32'hF0F0; req0_b = 32'hFF00;
    tick();
    req0_valid = 1'b0;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("no%0d_state", k), 32'(state_dbg), 32'(RESP));
      check($sformatf("no%0d_rspv0", k), 32'(rsp0_valid), 1);
      check($sformatf("no%0d_rspv1", k), 32'(rsp1_valid), 0);
      check($sformatf("no%0d_data", k), rsp_data, 32'h0000F000);
      tick();
    end
    rsp0_ready = 1'b1;
    tick();
    check("no_idle", 32'(state_dbg), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single registered ALU (one-cycle latency, `WORD_SIZE` = 32) between two requesters: requester 0 is the execute path and requester 1 is the load/store address generator.
- Accepts one operation at a time through a valid/ready handshake.
- Sequences the ALU through drive, settle and capture steps, then returns the tagged result with response backpressure.
- Sits between the decode/regfile datapath and the alu instance.

Parameters:
- WORD_SIZE, 32, operand/result width.
- CTRL_W, 4, ALU control code width; codes are passed through unmodified.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_ctrl  input  CTRL_W  requester 0 ALU control code
- req0_a  input  WORD_SIZE  requester 0 operand 1
- req0_b  input  WORD_SIZE  requester 0 operand 2
- req1_valid / req1_ready / req1_ctrl / req1_a / req1_b  same widths and meaning, requester 1
- rsp0_valid  output  1  result for requester 0 available
- rsp0_ready  input  1  requester 0 takes result
- rsp1_valid  output  1  result for requester 1 available
- rsp1_ready  input  1  requester 1 takes result
- rsp_data  output  WORD_SIZE  result, shared bus
- alu_control  output  CTRL_W  to alu control
- alu_in_1  output  WORD_SIZE  to alu in_1
- alu_in_2  output  WORD_SIZE  to alu in_2
- alu_out  input  WORD_SIZE  from alu out, registered inside the ALU
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clocking and reset:
  - Clock is clk.
  - reset is synchronous, active-high.
- Reset values:
  - State is IDLE.
  - All ready and valid outputs are 0.
  - rsp_data, alu_in_1 and alu_in_2 are 0.
  - alu_control is ALU_ADD.
  - The grant pointer is set so that requester 0 wins the first tie.
- FSM states: IDLE, EXEC, COLLECT, RESP.
- IDLE:
  - reqN_ready is combinational and is asserted only for the requester that wins arbitration while it has valid=1.
  - At most one ready is high at a time.
  - An accept edge is a cycle with valid & ready for requester N. On that edge, capture ctrl, a and b into operand registers and N into the owner tag, then go to EXEC.
  - With no valid requests, stay in IDLE.
- Arbitration (default): round-robin.
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - The pointer updates only on an accept edge.
- EXEC: alu_control, alu_in_1 and alu_in_2 are driven from the operand registers. The ALU registers its result at the end of this cycle. Unconditionally go to COLLECT.
- COLLECT:
  - The operand outputs are still held, so alu_out is valid.
  - rsp_data <= alu_out at the end of the cycle, then go to RESP.
- RESP:
  - rspN_valid = 1 for the owner tag only.
  - rsp_data is held.
  - On rspN_ready, go to IDLE. The next accept occurs no earlier than the following cycle.
  - Without ready, stay in RESP indefinitely with data stable.
- Latency:
  - Accept edge at cycle 0, rspN_valid high from cycle 3.
  - Minimum issue interval is 4 cycles.
- Operand outputs in IDLE keep their last value, so there is no ALU toggling.
- Requests that are not accepted may change or drop valid freely; no request state is retained.
- reset mid-operation (any state):
  - Go to IDLE.
  - The in-flight result is discarded and no response is issued.
  - The grant pointer is reset.
- The rsp_ready of the non-owner requester is ignored.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins a tie, and the grant pointer is removed.
- Undefined: round-robin as described in Behaviour.
- Latency and handshake rules are identical in both builds.

Decomposition:
- The ALU control code constants stay in the existing alu_signal.svh (ALU_ADD … ALU_SRA).
- New package alu_arb_pkg contains:
  - the FSM state enum (IDLE, EXEC, COLLECT, RESP);
  - the owner-tag type (1 bit);
  - a struct grouping {ctrl, a, b}.
- One sub-module, alu_rr_arbiter2:
  - Combinational 2-way grant from valid bits plus pointer.
  - Pointer register updated on an accept pulse.
  - Fixed-priority variant selected by ALU_ARB_FIXED_PRIO_EN.

Test Plan:
- Single op:
  - Stimulus: req0 ADD a=5, b=7; rsp0_ready held at 1.
  - Response: req0_ready at cycle 0; rsp0_valid at cycle 3 with rsp_data=12; busy 1 for cycles 1–3.
- Simultaneous requests:
  - Stimulus: both valid continuously; req0 SUB 10,3; req1 ADD 0x1000,0x20.
  - Response: grants alternate 0,1,0,…; responses 7 and 0x1020 tagged to the correct port; with ALU_ARB_FIXED_PRIO_EN defined, only req0 is served.
- Backpressure:
  - Stimulus: req1 XOR 0xFF00,0x0FF0 with rsp1_ready low for 5 cycles.
  - Response: rsp1_valid held; rsp_data stays 0xF0F0; no new accept while req0 is valid; IDLE after ready.
- Shift pass-through:
  - Stimulus: req0 SRA a=0x80000000, b=4.
  - Response: rsp_data=0xF8000000; alu_control equals the SRA code in EXEC and COLLECT.
- Reset mid-op:
  - Stimulus: assert reset during COLLECT.
  - Response: next cycle IDLE; no rspN_valid; outputs at reset values; a following req1 ADD 1,1 returns 2.
- Non-owner ready:
  - Stimulus: in RESP owned by 0, rsp1_ready=1 and rsp0_ready=0.
  - Response: stays in RESP and rsp0_valid remains 1.
